// File: rtl/spike_addr_packer_if.sv
// Event-side and stack-side signal bundle for spike_addr_packer.
//   slave  : the packer (consumes events and stk_wait, drives commands/status)
//   master : the environment (event source plus address stack)
// Signals: ev_valid/ev_ready/ev_tag/ev_nid/ev_flush (event handshake),
//          ctl_out/data_out/stk_wait (stack command bus),
//          ovf_err/mirror_depth (status/debug).
interface spike_addr_packer_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  ev_valid;
  logic                  ev_ready;
  logic [3:0]            ev_tag;
  logic [7:0]            ev_nid;
  logic                  ev_flush;
  logic [1:0]            ctl_out;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  stk_wait;
  logic                  ovf_err;
  logic [1:0]            mirror_depth;

  modport slave (
    input  ev_valid, ev_tag, ev_nid, ev_flush, stk_wait,
    output ev_ready, ctl_out, data_out, ovf_err, mirror_depth
  );

  modport master (
    output ev_valid, ev_tag, ev_nid, ev_flush, stk_wait,
    input  ev_ready, ctl_out, data_out, ovf_err, mirror_depth
  );
endinterface

// File: rtl/spike_addr_packer.sv
// spike_addr_packer: feeds the 3-deep address stack. Accepts spike events,
// merges eligible consecutive events into pair words, issues singles on
// timeout/flush, and mirrors stack depth so the stack never overflows.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   bus (slave)  : event handshake, stack ctl/data command, stk_wait,
//                  sticky ovf_err, mirror_depth debug count
// Optional (macro PACK_STATS_EN): pair_cnt, single_cnt, stall_cnt,
//   16-bit saturating counters cleared on reset.
module spike_addr_packer #(
  parameter int DATA_WIDTH = 16,
  parameter int HOLD_CYC   = 4,
  parameter int DEPTH_MAX  = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  spike_addr_packer_if.slave    bus
`ifdef PACK_STATS_EN
  ,
  output logic [15:0]           pair_cnt,
  output logic [15:0]           single_cnt,
  output logic [15:0]           stall_cnt
`endif
);

  typedef enum logic [1:0] {EMPTY, HOLD, FLUSH_B} state_t;

  localparam logic [3:0] T_LAST     = 4'(HOLD_CYC - 1);
  localparam logic [2:0] LIM_SINGLE = 3'(DEPTH_MAX - 1);
  localparam logic [2:0] LIM_PAIR   = 3'(DEPTH_MAX - 2);

  state_t                state, state_n;
  logic [3:0]            timer, timer_n;
  logic [3:0]            hold_tag;
  logic [7:0]            hold_nid;
  logic                  ld;
  logic [1:0]            ctl_q, ctl_n;
  logic [DATA_WIDTH-1:0] data_q, data_n;
  logic                  ready_q, ready_n;
  logic                  ovf_q;
  logic [1:0]            depth_q;
  logic [2:0]            d_now, d_next;
  logic                  accept, eligible, single_ok;

  function automatic logic [2:0] words(input logic [1:0] c);
    return (c == 2'b11) ? 3'd2 : (c == 2'b01) ? 3'd1 : 3'd0;
  endfunction

  function automatic logic [2:0] drain(input logic [2:0] s);
    return (s == 3'd0) ? 3'd0 : s - 3'd1;
  endfunction

  // d_now: depth in the cycle the next command will be presented.
  // d_next: depth one cycle later, used to register ev_ready ahead of time.
  assign d_now     = drain({1'b0, depth_q} + words(ctl_q));
  assign d_next    = drain(d_now + words(ctl_n));
  assign single_ok = (d_now <= LIM_SINGLE);
  assign accept    = bus.ev_valid && ready_q;
  assign eligible  = (bus.ev_tag == hold_tag) && (bus.ev_nid[7:4] == hold_tag);

  always_comb begin
    state_n = state;
    timer_n = timer;
    ld      = 1'b0;
    ctl_n   = 2'b00;
    data_n  = data_q;
    unique case (state)
      EMPTY: begin
        if (accept) begin
          if (bus.ev_flush) begin
            ctl_n  = 2'b01;
            data_n = {bus.ev_tag, 4'b0000, bus.ev_nid};
          end else begin
            ld      = 1'b1;
            timer_n = '0;
            state_n = HOLD;
          end
        end
      end
      HOLD: begin
        if (accept) begin
          if (eligible) begin
            ctl_n   = 2'b11;
            data_n  = {hold_tag, bus.ev_nid[3:0], hold_nid};
            state_n = EMPTY;
          end else begin
            ctl_n   = 2'b01;
            data_n  = {hold_tag, 4'b0000, hold_nid};
            ld      = 1'b1;
            timer_n = '0;
            state_n = bus.ev_flush ? FLUSH_B : HOLD;
          end
        end else if (timer == T_LAST) begin
          // Timer stays frozen at T_LAST until a single fits.
          if (single_ok) begin
            ctl_n   = 2'b01;
            data_n  = {hold_tag, 4'b0000, hold_nid};
            state_n = EMPTY;
          end
        end else begin
          timer_n = timer + 4'd1;
        end
      end
      FLUSH_B: begin
        if (single_ok) begin
          ctl_n   = 2'b01;
          data_n  = {hold_tag, 4'b0000, hold_nid};
          state_n = EMPTY;
        end
      end
      default: state_n = EMPTY;
    endcase
  end

  // In HOLD the incoming event is unknown when ev_ready is registered, so
  // readiness there requires pair credit, which also covers a single.
  always_comb begin
    ready_n = 1'b0;
    unique case (state_n)
      EMPTY:   ready_n = (d_next <= LIM_SINGLE);
      HOLD:    ready_n = (d_next <= LIM_PAIR);
      default: ready_n = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= EMPTY;
      timer    <= '0;
      hold_tag <= '0;
      hold_nid <= '0;
      ctl_q    <= '0;
      data_q   <= '0;
      ready_q  <= 1'b0;
      ovf_q    <= 1'b0;
      depth_q  <= '0;
    end else begin
      state   <= state_n;
      timer   <= timer_n;
      if (ld) begin
        hold_tag <= bus.ev_tag;
        hold_nid <= bus.ev_nid;
      end
      ctl_q   <= ctl_n;
      data_q  <= data_n;
      ready_q <= ready_n;
      ovf_q   <= ovf_q | bus.stk_wait;
      depth_q <= d_now[1:0];
    end
  end

  assign bus.ev_ready     = ready_q;
  assign bus.ctl_out      = ctl_q;
  assign bus.data_out     = data_q;
  assign bus.ovf_err      = ovf_q;
  assign bus.mirror_depth = depth_q;

`ifdef PACK_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      pair_cnt   <= '0;
      single_cnt <= '0;
      stall_cnt  <= '0;
    end else begin
      if (ctl_n == 2'b11 && pair_cnt != '1)
        pair_cnt <= pair_cnt + 16'd1;
      if (ctl_n == 2'b01 && single_cnt != '1)
        single_cnt <= single_cnt + 16'd1;
      if (bus.ev_valid && !ready_q && stall_cnt != '1)
        stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_spike_addr_packer.sv
// Self-checking bench for spike_addr_packer: a table of back-to-back events
// with hand-computed commands and depths, then hand-written sequences for
// timeout, mismatch, flush, overflow flag, mid-hold reset and a pair stream
// against a behavioural stack occupancy model.
module tb_spike_addr_packer;
  localparam int HOLD_CYC  = 4;
  localparam int DEPTH_MAX = 3;

  logic clk;
  logic rst;
  logic man_wait;
  logic mdl_wait;
  logic mon_en;
  int   occ;
  int   nb;
  int   errors;
  int   checks;

  spike_addr_packer_if #(.DATA_WIDTH(16)) bus ();

`ifdef PACK_STATS_EN
  logic [15:0] pair_cnt, single_cnt, stall_cnt;
`endif

  spike_addr_packer #(
    .DATA_WIDTH(16),
    .HOLD_CYC  (HOLD_CYC),
    .DEPTH_MAX (DEPTH_MAX)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef PACK_STATS_EN
    ,
    .pair_cnt  (pair_cnt),
    .single_cnt(single_cnt),
    .stall_cnt (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural stack: pushes n words, emits one per cycle while non-empty.
  assign nb = (bus.ctl_out == 2'b11) ? 2 : (bus.ctl_out == 2'b01) ? 1 : 0;
  assign mdl_wait = (occ + nb > DEPTH_MAX);
  assign bus.stk_wait = man_wait | mdl_wait;

  always @(posedge clk) begin
    if (rst) occ <= 0;
    else     occ <= (occ + nb == 0) ? 0 : occ + nb - 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      chk("mirror_vs_model", 32'(bus.mirror_depth), occ);
      chk("stack_bound", {31'b0, occ > DEPTH_MAX}, 32'd0);
      chk("ctl_not_10", {31'b0, bus.ctl_out == 2'b10}, 32'd0);
    end
  end

  task automatic send(input logic [3:0] t, input logic [7:0] n, input logic f);
    int unsigned w;
    w = 0;
    @(negedge clk);
    bus.ev_tag   = t;
    bus.ev_nid   = n;
    bus.ev_flush = f;
    bus.ev_valid = 1'b1;
    while (!bus.ev_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!bus.ev_ready) begin
      checks++;
      errors++;
      $display("FAIL send_ready_timeout: got ev_ready=0 expected 1 within 50 cycles");
    end
    @(posedge clk);
    #1;
    bus.ev_valid = 1'b0;
    bus.ev_flush = 1'b0;
  endtask

  task automatic reset_check(input string nm);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk({nm, "_ctl"},   32'(bus.ctl_out), 32'd0);
    chk({nm, "_data"},  32'(bus.data_out), 32'd0);
    chk({nm, "_ready"}, 32'(bus.ev_ready), 32'd0);
    chk({nm, "_ovf"},   32'(bus.ovf_err), 32'd0);
    chk({nm, "_depth"}, 32'(bus.mirror_depth), 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic [3:0]  tag;
    logic [7:0]  nid;
    logic        flush;
    logic [1:0]  ctl;
    logic [15:0] data;
    logic [1:0]  depth;
  } vec_t;

  vec_t tbl [11];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] tg;
    logic [7:0] an, bn;
    errors = 0;
    checks = 0;
    rst = 1'b1;
    man_wait = 1'b0;
    mon_en = 1'b0;
    bus.ev_valid = 1'b0;
    bus.ev_tag = '0;
    bus.ev_nid = '0;
    bus.ev_flush = 1'b0;

    // Command visible right after the accept edge; depth as seen then.
    tbl[0]  = '{4'h3, 8'h15, 1'b0, 2'b00, 16'h0000, 2'd0};
    tbl[1]  = '{4'h3, 8'h37, 1'b0, 2'b11, 16'h3715, 2'd0};
    tbl[2]  = '{4'h2, 8'h40, 1'b0, 2'b00, 16'h3715, 2'd1};
    tbl[3]  = '{4'h2, 8'h51, 1'b0, 2'b01, 16'h2040, 2'd0};
    tbl[4]  = '{4'h2, 8'h2E, 1'b0, 2'b11, 16'h2E51, 2'd0};
    tbl[5]  = '{4'h9, 8'h33, 1'b1, 2'b01, 16'h9033, 2'd1};
    tbl[6]  = '{4'h4, 8'h01, 1'b0, 2'b00, 16'h9033, 2'd1};
    tbl[7]  = '{4'h4, 8'h4F, 1'b1, 2'b11, 16'h4F01, 2'd0};
    tbl[8]  = '{4'hA, 8'hA0, 1'b0, 2'b00, 16'h4F01, 2'd1};
    tbl[9]  = '{4'hB, 8'hB5, 1'b0, 2'b01, 16'hA0A0, 2'd0};
    tbl[10] = '{4'hB, 8'hB9, 1'b0, 2'b11, 16'hB9B5, 2'd0};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_ctl",   32'(bus.ctl_out), 32'd0);
    chk("rst_data",  32'(bus.data_out), 32'd0);
    chk("rst_ready", 32'(bus.ev_ready), 32'd0);
    chk("rst_ovf",   32'(bus.ovf_err), 32'd0);
    chk("rst_depth", 32'(bus.mirror_depth), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    mon_en = 1'b1;

    for (int i = 0; i < 11; i++) begin
      send(tbl[i].tag, tbl[i].nid, tbl[i].flush);
      chk($sformatf("vec%0d_ctl", i),   32'(bus.ctl_out), 32'(tbl[i].ctl));
      chk($sformatf("vec%0d_data", i),  32'(bus.data_out), 32'(tbl[i].data));
      chk($sformatf("vec%0d_depth", i), 32'(bus.mirror_depth), 32'(tbl[i].depth));
    end

    // Timeout: lone event issues exactly HOLD_CYC cycles after acceptance.
    reset_check("rst2");
    send(4'h1, 8'hAA, 1'b0);
    chk("timeout_accept_ctl", 32'(bus.ctl_out), 32'd0);
    for (int k = 1; k <= HOLD_CYC + 2; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("timeout_ctl_k%0d", k), 32'(bus.ctl_out), (k == HOLD_CYC) ? 32'd1 : 32'd0);
      if (k == HOLD_CYC) chk("timeout_data", 32'(bus.data_out), 32'h10AA);
    end

    // Mismatched nibble: A single now, B single after HOLD_CYC idle cycles.
    send(4'h2, 8'h40, 1'b0);
    send(4'h2, 8'h51, 1'b0);
    chk("mismatch_a_ctl",  32'(bus.ctl_out), 32'd1);
    chk("mismatch_a_data", 32'(bus.data_out), 32'h2040);
    for (int k = 1; k <= HOLD_CYC + 2; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("mismatch_b_ctl_k%0d", k), 32'(bus.ctl_out), (k == HOLD_CYC) ? 32'd1 : 32'd0);
      if (k == HOLD_CYC) chk("mismatch_b_data", 32'(bus.data_out), 32'h2051);
    end

    // Ineligible flushed B: A single, then B single from FLUSH_B.
    send(4'h2, 8'h40, 1'b0);
    send(4'h6, 8'h6A, 1'b1);
    chk("flushb_a_ctl",  32'(bus.ctl_out), 32'd1);
    chk("flushb_a_data", 32'(bus.data_out), 32'h2040);
    chk("flushb_ready",  32'(bus.ev_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("flushb_b_ctl",   32'(bus.ctl_out), 32'd1);
    chk("flushb_b_data",  32'(bus.data_out), 32'h606A);
    chk("flushb_b_ready", 32'(bus.ev_ready), 32'd1);
    @(posedge clk);
    #1;
    chk("flushb_idle_ctl",  32'(bus.ctl_out), 32'd0);
    chk("flushb_idle_data", 32'(bus.data_out), 32'h606A);

    // Sticky overflow flag.
    @(negedge clk);
    man_wait = 1'b1;
    @(posedge clk);
    #1;
    chk("ovf_set", 32'(bus.ovf_err), 32'd1);
    @(negedge clk);
    man_wait = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("ovf_sticky", 32'(bus.ovf_err), 32'd1);

    // Reset one cycle after accepting an event discards it.
    send(4'h5, 8'h12, 1'b0);
    chk("midrst_accept_ctl", 32'(bus.ctl_out), 32'd0);
    reset_check("midrst");
    for (int k = 1; k <= HOLD_CYC + 2; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("midrst_quiet_k%0d", k), 32'(bus.ctl_out), 32'd0);
    end

    // Stream of 8 eligible pairs against the stack model.
    for (int p = 0; p < 8; p++) begin
      tg = 4'(p + 1);
      an = 8'(8'h30 + p);
      bn = {tg, 4'(p)};
      send(tg, an, 1'b0);
      send(tg, bn, 1'b0);
      chk($sformatf("stream%0d_ctl", p),  32'(bus.ctl_out), 32'd3);
      chk($sformatf("stream%0d_data", p), 32'(bus.data_out), {16'd0, tg, 4'(p), an});
    end
    repeat (4) @(posedge clk);
    #1;
    chk("stream_ovf", 32'(bus.ovf_err), 32'd0);
    chk("stream_wait", 32'(bus.stk_wait), 32'd0);

    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
